// File: rtl/tim_arith_share_ctrl_if.sv
// Request/response bundle for the shared add/multiply unit.
// The requester side (bench or upstream fabric) uses master; the scheduler uses slave.
interface tim_arith_share_ctrl_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_op;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [2*WIDTH-1:0]       rsp_data;
   logic                     busy;
   logic [15:0]              op_count;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
   );
endinterface

// File: rtl/tim_arith_share_ctrl.sv
// Round-robin arbiter sharing one add/multiply datapath among NUM_REQ requesters.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result until taken.
module tim_arith_share_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = 2
) (
   input logic                  clk,
   input logic                  rst,
   tim_arith_share_ctrl_if.slave bus
);
   localparam int SLOTS = 2 ** ID_W;
   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     rr_ptr_reg;
   logic [WIDTH-1:0]    a_q_reg, b_q_reg;
   logic                op_q_reg;
   logic [ID_W-1:0]     id_q_reg;
   logic                rsp_valid_reg;
   logic [ID_W-1:0]     rsp_id_reg;
   logic [2*WIDTH-1:0]  rsp_data_reg;
   logic [15:0]         op_count_reg;

   // Requester lanes padded up to a power of two so ID_W-wide indices never overrun.
   logic [WIDTH-1:0]    a_arr [SLOTS];
   logic [WIDTH-1:0]    b_arr [SLOTS];
   logic [SLOTS-1:0]    valid_ext;
   logic [SLOTS-1:0]    op_ext;

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < NUM_REQ) begin : g_real
            assign a_arr[gi]     = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]     = bus.req_b[gi*WIDTH +: WIDTH];
            assign valid_ext[gi] = bus.req_valid[gi];
            assign op_ext[gi]    = bus.req_op[gi];
         end else begin : g_pad
            assign a_arr[gi]     = '0;
            assign b_arr[gi]     = '0;
            assign valid_ext[gi] = 1'b0;
            assign op_ext[gi]    = 1'b0;
         end
      end
   endgenerate

   logic            win_found;
   logic [ID_W-1:0] win_id;
   logic [ID_W:0]   cand_sum;
   logic [ID_W:0]   ptr_inc;
   logic [ID_W-1:0] rr_ptr_next;

   // Scan downward in offset so the lowest offset from rr_ptr is the last (winning) write.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand_sum  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
         if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
         if (valid_ext[cand_sum[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand_sum[ID_W-1:0];
         end
      end
      ptr_inc     = {1'b0, win_id} + (ID_W+1)'(1);
      rr_ptr_next = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[ID_W-1:0];
   end

   logic             grant;
   logic             rsp_hs;
   logic [SLOTS-1:0] ready_ext;

   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      rsp_hs     = 1'b0;
      case (state_reg)
         IDLE: if (win_found) begin
            grant      = 1'b1;
            state_next = EXEC;
         end
         EXEC: state_next = RESP;
         RESP: if (bus.rsp_ready) begin
            rsp_hs     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      ready_ext = SLOTS'(grant) << win_id;
   end

   logic [WIDTH:0]     sum_w;
   logic [2*WIDTH-1:0] prod_w;
   logic [2*WIDTH-1:0] result;

   always_comb begin
      sum_w  = {1'b0, a_q_reg} + {1'b0, b_q_reg};
      prod_w = (2*WIDTH)'(a_q_reg) * (2*WIDTH)'(b_q_reg);
      result = op_q_reg ? prod_w : (2*WIDTH)'(sum_w);
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg    <= '0;
         a_q_reg       <= '0;
         b_q_reg       <= '0;
         op_q_reg      <= 1'b0;
         id_q_reg      <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
         op_count_reg  <= '0;
      end else begin
         if (grant) begin
            a_q_reg    <= a_arr[win_id];
            b_q_reg    <= b_arr[win_id];
            op_q_reg   <= op_ext[win_id];
            id_q_reg   <= win_id;
            rr_ptr_reg <= rr_ptr_next;
         end
         if (state_reg == EXEC) begin
            rsp_data_reg  <= result;
            rsp_id_reg    <= id_q_reg;
            rsp_valid_reg <= 1'b1;
         end
         if (rsp_hs) begin
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 16'd1;
         end
      end
   end

   assign bus.req_ready = ready_ext[NUM_REQ-1:0];
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.op_count  = op_count_reg;

   a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
   a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.rsp_valid && !bus.rsp_ready) |=> ($stable(bus.rsp_data) && $stable(bus.rsp_id)));
endmodule
